uart_tx_interface: RTL and testbench

// - Memory-mapped UART transmitter peripheral: responder end of the mapper's

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_interface.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_interface.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and register map for the UART transmit peripheral.
// Register index is addr[3:2]; status bit positions match the STATUS layout.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: pop_data always presents the head entry.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_interface.sv
// Memory-mapped 8N1 UART transmitter: bus writes fill a byte FIFO which the
// serialiser drains LSB first, each bit lasting divisor+1 clocks.
module uart_tx_interface
    import uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        write_req,
    input  logic        read_req,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    output logic        tx
);

    localparam int CW = FIFO_DEPTH_LOG2 + 1;

    logic [1:0]    reg_sel;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          overflow_evt;
    logic          status_rd;
    logic [15:0]   divisor;
    logic [31:0]   status_word;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    tx_state_t   state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic        tx_next;

    assign reg_sel      = addr[3:2];
    assign push         = write_req && (reg_sel == REG_DATA) && byte_enable[0];
    assign overflow_evt = push && fifo_full && !pop;
    assign status_rd    = read_req && (reg_sel == REG_STATUS);
    assign unused_bits  = ^{addr[1:0], write_data[31:16], byte_enable[3:2]};

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (write_data[7:0]),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor <= DEFAULT_DIVISOR;
        end else if (write_req && reg_sel == REG_DIVISOR) begin
            if (byte_enable[0]) divisor[7:0]  <= write_data[7:0];
            if (byte_enable[1]) divisor[15:8] <= write_data[15:8];
        end
    end

    // An overflow landing on the clearing read wins, so no event is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             overflow <= 1'b0;
        else if (overflow_evt) overflow <= 1'b1;
        else if (status_rd)    overflow <= 1'b0;
    end

    always_comb begin
        status_word                        = '0;
        status_word[ST_BUSY]               = (state != IDLE) || !fifo_empty;
        status_word[ST_FULL]               = fifo_full;
        status_word[ST_EMPTY]              = fifo_empty;
        status_word[ST_OVERFLOW]           = overflow;
        status_word[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_STATUS:  rd_mux = status_word;
            REG_DIVISOR: rd_mux = {16'h0000, divisor};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data       <= '0;
            read_data_valid <= 1'b0;
        end else begin
            read_data       <= read_req ? rd_mux : '0;
            read_data_valid <= read_req;
        end
    end

    // The divisor is sampled only when a bit period is (re)loaded, so a
    // divisor write never stretches or shortens the bit in flight.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                    shift_next = fifo_data;
                    cnt_next   = divisor;
                end
            end
            START: begin
                if (cnt == '0) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                    cnt_next     = divisor;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_next   = divisor;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_next = STOP;
                    else                 bit_idx_next = bit_idx + 3'd1;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                        shift_next = fifo_data;
                        cnt_next   = divisor;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the next state so the line moves with the FSM.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_interface.sv
// Scoreboard bench: stimulus queues expected bytes and read results; monitors
// decode the serial line as whole frames and check every read response.
module tb_uart_tx_interface;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  addr = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  byte_enable = '0;
    logic        write_req = 1'b0;
    logic        read_req = 1'b0;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        tx;

    uart_tx_interface #(
        .FIFO_DEPTH_LOG2 (3),
        .DEFAULT_DIVISOR (16'd433)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .addr            (addr),
        .write_data      (write_data),
        .byte_enable     (byte_enable),
        .write_req       (write_req),
        .read_req        (read_req),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .tx              (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t     rq[$];
    logic [7:0]  exp_bytes[$];
    int          starts[$];
    int          bit_p = 434;
    logic [15:0] cur_div = 16'd433;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] status(int busy, int full, int empty, int ovf, int count);
        return 32'(busy + 2 * full + 4 * empty + 8 * ovf + 256 * count);
    endfunction

    // Frame monitor: a frame is 10 bit periods of bit_p samples each.
    bit         m_active = 1'b0;
    bit         m_bad = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_byte = '0;
    logic [7:0] m_act = '0;

    always @(negedge clk) begin
        if (reset) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (tx == 1'b0) begin
                m_active = 1'b1;
                m_cnt    = 1;
                m_bad    = 1'b0;
                m_act    = '0;
                starts.push_back(cyc);
                if (exp_bytes.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected_frame: got start bit expected idle line (cycle %0d)", cyc);
                    m_byte = '0;
                end else begin
                    m_byte = exp_bytes.pop_front();
                end
            end
        end else begin
            int   seg;
            logic lvl;
            seg = m_cnt / bit_p;
            if (seg == 0)      lvl = 1'b0;
            else if (seg == 9) lvl = 1'b1;
            else               lvl = m_byte[seg-1];
            if (tx !== lvl) m_bad = 1'b1;
            if (seg >= 1 && seg <= 8 && (m_cnt % bit_p) == bit_p / 2) m_act[seg-1] = tx;
            m_cnt++;
            if (m_cnt == 10 * bit_p) begin
                chk("tx_byte", 32'(m_act), 32'(m_byte));
                chk("tx_frame_shape", 32'(m_bad), 32'd0);
                m_active = 1'b0;
            end
        end
    end

    // Read monitor.
    always @(negedge clk) begin
        if (read_data_valid) begin
            if (rq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got valid data %h expected no response", read_data);
            end else begin
                rd_exp_t e;
                e = rq.pop_front();
                chk("rd_data", read_data, e.data);
                chk("rd_latency", 32'(cyc), 32'(e.due));
            end
        end else begin
            chk("rd_idle_zero", read_data, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] rexp);
        rd_exp_t e;
        addr        = a;
        write_data  = d;
        byte_enable = be;
        write_req   = w;
        read_req    = r;
        if (r) begin
            e.data = rexp;
            e.due  = cyc + 1;
            rq.push_back(e);
        end
        step();
        write_req = 1'b0;
        read_req  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        bus(1'b1, 1'b0, a, d, be, 32'd0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        bus(1'b0, 1'b1, a, 32'd0, 4'd0, exp);
    endtask

    task automatic send(input logic [7:0] b);
        exp_bytes.push_back(b);
        wr(4'h0, {24'h0, b}, 4'b0001);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((exp_bytes.size() != 0 || m_active) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d bytes outstanding expected 0", exp_bytes.size());
        end
        step();
        step();
    endtask

    task automatic set_div(input logic [15:0] v);
        wr(4'h8, {16'h0, v}, 4'b0011);
        cur_div = v;
        bit_p   = int'(v) + 1;
    endtask

    initial begin
        int c;
        int n;
        int s0;

        // Reset state.
        repeat (3) step();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_valid", 32'(read_data_valid), 32'd0);
        chk("reset_rdata", read_data, 32'd0);
        reset = 1'b0;
        step();

        // Register map after reset.
        rd(4'h8, 32'h0000_01B1);
        rd(4'h0, 32'd0);
        rd(4'hC, 32'd0);
        rd(4'hD, 32'd0);
        rd(4'h4, status(0, 0, 1, 0, 0));

        // Divisor byte enables and same-cycle write+read.
        wr(4'h8, 32'h0000_AB00, 4'b0010);
        rd(4'h8, 32'h0000_ABB1);
        bus(1'b1, 1'b1, 4'h8, 32'h0000_0003, 4'b0011, 32'h0000_ABB1);
        cur_div = 16'd3;
        bit_p   = 4;
        rd(4'h8, 32'd3);
        wr(4'h8, 32'hFFFF_FFFF, 4'b1100);
        rd(4'h8, 32'd3);

        // Single frame 0x55: start latency, busy while sending, idle after.
        n = starts.size();
        c = cyc;
        send(8'h55);
        repeat (4) step();
        rd(4'h4, status(1, 0, 1, 0, 0));
        wait_idle(200);
        if (starts.size() > n) chk("start_latency", 32'(starts[n]), 32'(c + 2));
        else chk("start_latency", 32'd0, 32'(c + 2));
        rd(4'h4, status(0, 0, 1, 0, 0));

        // DATA write without byte lane 0 pushes nothing.
        wr(4'h0, 32'h0000_00AA, 4'b1110);
        repeat (4) step();
        rd(4'h4, status(0, 0, 1, 0, 0));

        // Fill to depth, overflow, sticky clear, push+pop at full, back-to-back.
        n = starts.size();
        c = cyc;
        for (int i = 0; i < 9; i++) send(8'($urandom));
        rd(4'h4, status(1, 1, 0, 0, 8));
        wr(4'h0, 32'h0000_00EE, 4'b0001);
        rd(4'h4, status(1, 1, 0, 1, 8));
        rd(4'h4, status(1, 1, 0, 0, 8));
        if (starts.size() > n) begin
            s0 = starts[n];
            chk("burst_start", 32'(s0), 32'(c + 2));
            while (cyc < s0 + 39) step();
            send(8'($urandom));
            rd(4'h4, status(1, 1, 0, 0, 8));
        end else begin
            chk("burst_start", 32'd0, 32'(c + 2));
        end
        wait_idle(1000);
        chk("burst_frames", 32'(starts.size() - n), 32'd10);
        for (int k = 1; k < 10; k++) begin
            if (starts.size() > n + k)
                chk("back_to_back_gap", 32'(starts[n+k] - starts[n+k-1]), 32'(10 * bit_p));
        end
        rd(4'h4, status(0, 0, 1, 0, 0));

        // Randomised traffic at random divisors.
        for (int it = 0; it < 6; it++) begin
            int nb;
            int sent;
            int guard;
            set_div(16'($urandom_range(0, 5)));
            nb    = $urandom_range(1, 8);
            sent  = 0;
            guard = 0;
            while (sent < nb && guard < 200) begin
                int          r;
                logic [1:0]  sel;
                logic [3:0]  a;
                logic [7:0]  b;
                r = $urandom_range(0, 3);
                guard++;
                if (r == 0) begin
                    step();
                end else if (r == 1) begin
                    sel = ($urandom_range(0, 2) == 0) ? 2'd0 : (($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3);
                    a   = {sel, 2'($urandom)};
                    rd(a, (sel == 2'd2) ? {16'h0, cur_div} : 32'd0);
                end else begin
                    b = 8'($urandom);
                    exp_bytes.push_back(b);
                    bus(1'b1, r == 3, {2'd0, 2'($urandom)}, {24'($urandom), b}, 4'b0001, 32'd0);
                    sent++;
                end
            end
            wait_idle(2000);
            rd(4'h4, status(0, 0, 1, 0, 0));
        end

        // Reset in the middle of the data bits.
        set_div(16'd3);
        send(8'hC3);
        repeat (12) step();
        reset = 1'b1;
        #1;
        chk("tx_async_reset", 32'(tx), 32'd1);
        step();
        step();
        exp_bytes.delete();
        reset   = 1'b0;
        cur_div = 16'd433;
        bit_p   = 434;
        step();
        rd(4'h4, status(0, 0, 1, 0, 0));
        rd(4'h8, 32'h0000_01B1);
        repeat (3) step();

        chk("reads_pending", 32'(rq.size()), 32'd0);
        chk("bytes_pending", 32'(exp_bytes.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
